// File: rtl/corevx_defs.sv
// Shared definitions for the corevx memory-bus blocks.
package corevx_defs;

    // Avalon-style beat responses.
    localparam logic [1:0] AVL_RESP_OKAY = 2'b00;
    localparam logic [1:0] AVL_RESP_ERR  = 2'b11;

    // Memory arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACTIVE = 2'b01,
        ARB_RDATA  = 2'b10,
        ARB_WBURST = 2'b11
    } arb_state_e;

endpackage

// File: rtl/corevx_mem_arbiter.sv
// Two-master to one-slave burst-aware round-robin arbiter for the corevx
// memory bus. A grant is held until the whole granted burst has completed.
module corevx_mem_arbiter
    import corevx_defs::*;
#(
    parameter int ADDR_W  = 34,
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  s0_address,
    input  logic [BURST_W-1:0] s0_burstcount,
    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [31:0]        s0_writedata,
    input  logic [3:0]         s0_byteenable,
    output logic               s0_waitrequest,
    output logic               s0_readdatavalid,
    output logic [31:0]        s0_readdata,
    output logic [1:0]         s0_response,
    input  logic [ADDR_W-1:0]  s1_address,
    input  logic [BURST_W-1:0] s1_burstcount,
    input  logic               s1_read,
    input  logic               s1_write,
    input  logic [31:0]        s1_writedata,
    input  logic [3:0]         s1_byteenable,
    output logic               s1_waitrequest,
    output logic               s1_readdatavalid,
    output logic [31:0]        s1_readdata,
    output logic [1:0]         s1_response,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BURST_W-1:0] m_burstcount,
    output logic               m_read,
    output logic               m_write,
    output logic [31:0]        m_writedata,
    output logic [3:0]         m_byteenable,
    input  logic               m_waitrequest,
    input  logic               m_readdatavalid,
    input  logic [31:0]        m_readdata,
    input  logic [1:0]         m_response
);

    // A burstcount of zero is illegal on this bus and is handled as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
        logic [BURST_W-1:0] r;
        if (bc == {BURST_W{1'b0}}) begin
            r = BURST_W'(1);
        end else begin
            r = bc;
        end
        return r;
    endfunction

    arb_state_e         state_r, state_next_s;
    logic               grant_r, grant_next_s;   // 0 = s0, 1 = s1
    logic               prio_r, prio_next_s;     // master that wins a tie
    logic [BURST_W-1:0] beats_r, beats_next_s;

    logic               req0_s, req1_s;
    logic               g_read_s, g_write_s;
    logic [ADDR_W-1:0]  g_address_s;
    logic [BURST_W-1:0] g_burst_s, g_eff_s;
    logic [31:0]        g_wdata_s;
    logic [3:0]         g_be_s;
    logic               rd_acc_s, wr_acc_s;
    logic [BURST_W-1:0] wr_left_s;
    logic [1:0]         resp_s;

    assign req0_s = s0_read | s0_write;
    assign req1_s = s1_read | s1_write;
    assign g_eff_s = eff_burst(g_burst_s);

    // Read data fans out to both masters; only readdatavalid is steered.
    assign s0_readdata = m_readdata;
    assign s1_readdata = m_readdata;

    // Any non-OKAY slave code is reported to the master as an error.
    assign resp_s = (m_response == AVL_RESP_OKAY) ? AVL_RESP_OKAY : AVL_RESP_ERR;

    // Command acceptance; a read wins if a master drives both at once.
    assign rd_acc_s  = (state_r == ARB_ACTIVE) && g_read_s && !m_waitrequest;
    assign wr_acc_s  = ((state_r == ARB_ACTIVE) || (state_r == ARB_WBURST)) &&
                       g_write_s && !m_waitrequest && !rd_acc_s;
    assign wr_left_s = (state_r == ARB_ACTIVE) ? (g_eff_s - BURST_W'(1))
                                               : (beats_r - BURST_W'(1));

    // Select the command fields of the currently granted master.
    always_comb begin
        if (grant_r) begin
            g_read_s    = s1_read;
            g_write_s   = s1_write;
            g_address_s = s1_address;
            g_burst_s   = s1_burstcount;
            g_wdata_s   = s1_writedata;
            g_be_s      = s1_byteenable;
        end else begin
            g_read_s    = s0_read;
            g_write_s   = s0_write;
            g_address_s = s0_address;
            g_burst_s   = s0_burstcount;
            g_wdata_s   = s0_writedata;
            g_be_s      = s0_byteenable;
        end
    end

    // Next-state, grant/priority/beat bookkeeping and bus muxing.
    always_comb begin
        state_next_s     = state_r;
        grant_next_s     = grant_r;
        prio_next_s      = prio_r;
        beats_next_s     = beats_r;
        s0_waitrequest   = 1'b1;
        s1_waitrequest   = 1'b1;
        s0_readdatavalid = 1'b0;
        s1_readdatavalid = 1'b0;
        s0_response      = AVL_RESP_OKAY;
        s1_response      = AVL_RESP_OKAY;
        m_read           = 1'b0;
        m_write          = 1'b0;
        m_address        = {ADDR_W{1'b0}};
        m_burstcount     = {BURST_W{1'b0}};
        m_writedata      = 32'h0000_0000;
        m_byteenable     = 4'h0;
        case (state_r)
            ARB_IDLE: begin
                if (req0_s || req1_s) begin
                    grant_next_s = (req0_s && req1_s) ? prio_r : req1_s;
                    state_next_s = ARB_ACTIVE;
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_ACTIVE, ARB_WBURST: begin
                m_read       = (state_r == ARB_ACTIVE) ? g_read_s : 1'b0;
                m_write      = g_write_s;
                m_address    = g_address_s;
                m_burstcount = g_eff_s;
                m_writedata  = g_wdata_s;
                m_byteenable = g_be_s;
                if (grant_r) begin
                    s1_waitrequest = m_waitrequest;
                end else begin
                    s0_waitrequest = m_waitrequest;
                end
                if (rd_acc_s) begin
                    beats_next_s = g_eff_s;
                    state_next_s = ARB_RDATA;
                end else if (wr_acc_s) begin
                    beats_next_s = wr_left_s;
                    if (wr_left_s == {BURST_W{1'b0}}) begin
                        state_next_s = ARB_IDLE;
                        prio_next_s  = ~grant_r;
                    end else begin
                        state_next_s = ARB_WBURST;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ARB_RDATA: begin
                if (m_readdatavalid) begin
                    if (grant_r) begin
                        s1_readdatavalid = 1'b1;
                        s1_response      = resp_s;
                    end else begin
                        s0_readdatavalid = 1'b1;
                        s0_response      = resp_s;
                    end
                    beats_next_s = beats_r - BURST_W'(1);
                    if (beats_r <= BURST_W'(1)) begin
                        state_next_s = ARB_IDLE;
                        prio_next_s  = ~grant_r;
                    end else begin
                        state_next_s = ARB_RDATA;
                    end
                end else begin
                    state_next_s = ARB_RDATA;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // State, grant, priority and beat counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            grant_r <= 1'b0;
            prio_r  <= 1'b0;
            beats_r <= {BURST_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
            prio_r  <= prio_next_s;
            beats_r <= beats_next_s;
        end
    end

endmodule

// File: doc/corevx_mem_arbiter.md
# corevx_mem_arbiter

Two-master to one-slave arbiter for the burst memory bus driven by `corevx_cache`. It sits directly downstream of the instruction-side and data-side cache instances and merges their `m_*` ports onto the single system memory port. It is burst-aware and round-robin: a grant is held until the granted burst has fully completed.

## Interface

Parameters:
- `ADDR_W`, 34, byte address width; matches cache `m_address`.
- `BURST_W`, 5, burstcount width; legal burst lengths are 1..16.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, reset (see Reset below).
- `s0_address` / `s1_address`, in, ADDR_W, master byte address; sampled on the first accepted beat.
- `s0_burstcount` / `s1_burstcount`, in, BURST_W, burst length; sampled on the first accepted beat.
- `s0_read` / `s1_read`, in, 1, read command request.
- `s0_write` / `s1_write`, in, 1, write beat request.
- `s0_writedata` / `s1_writedata`, in, 32, write data.
- `s0_byteenable` / `s1_byteenable`, in, 4, write byte lanes.
- `s0_waitrequest` / `s1_waitrequest`, out, 1, stall to master.
- `s0_readdatavalid` / `s1_readdatavalid`, out, 1, read beat valid for this master.
- `s0_readdata` / `s1_readdata`, out, 32, read data; both are driven from `m_readdata`.
- `s0_response` / `s1_response`, out, 2, beat response; meaningful only when `readdatavalid` is high.
- `m_address`, out, ADDR_W, slave-side address.
- `m_burstcount`, out, BURST_W, slave-side burst length.
- `m_read`, out, 1, slave-side read.
- `m_write`, out, 1, slave-side write.
- `m_writedata`, out, 32, slave-side write data.
- `m_byteenable`, out, 4, slave-side byte lanes.
- `m_waitrequest`, in, 1, slave stall.
- `m_readdatavalid`, in, 1, slave read beat valid.
- `m_readdata`, in, 32, slave read data.
- `m_response`, in, 2, slave response: 2'b00 OKAY, 2'b11 error.

Reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.

## Operation

- **States:**
  - IDLE: no grant.
  - ACTIVE: granted master is passed through to the slave.
  - RDATA: waiting for read beats.
  - WBURST: remaining write beats.
- **IDLE:**
  - Both `sN_waitrequest` = 1; `m_read` = `m_write` = 0.
  - If any `sN_read|sN_write` is high, register `grant` and go to ACTIVE.
  - Both requesting: grant the master pointed to by `prio`. Single requester: grant it.
- **ACTIVE:** `m_*` command signals are a combinational copy of the granted master; `s_grant_waitrequest` = `m_waitrequest`; the other master's `waitrequest` = 1.
  - Read accepted (`m_read & !m_waitrequest`): latch `beats` = burstcount and go to RDATA.
  - Write accepted: latch `beats` = burstcount − 1. If 0, go to IDLE; else go to WBURST.
- **RDATA:**
  - `m_read` = 0; granted `waitrequest` = 1.
  - Each `m_readdatavalid` is routed to the granted master's `readdatavalid` and `response`, and decrements `beats`.
  - When the last beat arrives (`beats` == 1), go to IDLE.
- **WBURST:**
  - Pass-through as in ACTIVE, but `m_read` is forced to 0.
  - Each accepted write beat decrements `beats`; on the beat that reaches 0, go to IDLE.
- **Priority:** on every return to IDLE, `prio` <= the master that was not just served.
- **Read-data routing:** the non-granted master's `readdatavalid` is always 0.
- **Burstcount 0:** illegal; treated as 1.
- **Master protocol requirement:** a master holds `read`/`write` and all command fields stable until accepted. A master that withdraws a request while in ACTIVE leaves the arbiter in ACTIVE; no timeout exists.
- **Reset mid-burst:**
  - Return to IDLE with `prio` = s0.
  - The in-flight slave burst is abandoned; the slave must also be reset.
- **Write responses:** none; `response` is reported only for read beats.

## Timing

- Arbitration latency: 1 cycle. A request seen in IDLE at edge N can be accepted at the earliest at edge N+1.
- Command path is combinational in ACTIVE/WBURST: `sN` → `m_*`, and `m_waitrequest` → `sN_waitrequest`.
- Read data path is combinational: `m_readdatavalid` / `m_readdata` / `m_response` → granted master in the same cycle.
- Back-to-back bursts: at least one IDLE cycle between grants.
- Reset values:
  - `s0_waitrequest` = `s1_waitrequest` = 1.
  - `s*_readdatavalid` = 0.
  - `m_read` = `m_write` = 0.
  - `m_address`, `m_burstcount`, `m_writedata`, `m_byteenable` = 0.
  - `state` = IDLE, `prio` = s0, `beats` = 0.

## Structure

- `corevx_defs`:
  - response constants `AVL_RESP_OKAY` = 2'b00 and `AVL_RESP_ERR` = 2'b11.
  - arbiter state enum `{ARB_IDLE, ARB_ACTIVE, ARB_RDATA, ARB_WBURST}`.
- No sub-module: the beat counter and the muxing are inline. Single module `corevx_mem_arbiter`.

## Test plan

1. s0 reads 0x1000 with burst 4; slave returns D0..D3 with OKAY:
   - s0 sees 4 `readdatavalid` pulses with D0..D3.
   - `s1_readdatavalid` stays 0.
   - Arbiter returns to IDLE after D3.
2. s0 and s1 both request reads in the same cycle, `prio` = s0:
   - s0 is served first, then s1.
   - Repeated simultaneous requests then alternate s1, s0.
3. s1 writes burst 3 to 0x2000 while the slave stalls 2 cycles on beat 2:
   - `m_write` shows exactly 3 accepted beats with correct data and byteenable.
   - s0's pending read is granted only after beat 3.
4. s0 reads burst 2 and the slave returns beat 2 with `m_response` = 2'b11:
   - `s0_response` = 2'b11 on beat 2.
   - Arbiter returns to IDLE.
5. `rst` asserted during the RDATA of a burst-8 read after 3 beats:
   - The next cycle shows all outputs at their reset values.
   - A new s1 request is granted 1 cycle after `rst` deasserts.
6. Burstcount 0 read from s0:
   - Completes after 1 `readdatavalid` beat, then IDLE.
